display_readback: RTL and testbench
===================================

// Module: display_readback
// PURPOSE
//  Decoder/monitor for the 12-bit active-low multiplexed display bus (segs[11:0]).
//  Samples the bus, waits for a stable frame, and decodes it back to a 3-bit code,
//  the digit index and the 'on' flag. Emits one record per stable frame over valid/ready.
//  Sits beside the display driver for board self-check and testbench scoreboarding.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples required before a frame is reported (>=1)
//  CNT_W          3  stability counter width; must hold STABLE_CYCLES
// PORTS
//  clk       in   1   system clock, single clock domain
//  rst       in   1   asynchronous, active-high reset
//  segs_in   in   12  display bus: [6:0] segs A-G, [7] H (=~on), [8] point, [11:9] digit enables (active low)
//  ready     in   1   consumer accepts the record when ready&&valid at posedge clk
//  valid     out  1   record available
//  code_out  out  3   decoded code {A,B,C}
//  digit_out out  2   selected digit 0..2 (bit 9 -> 0, bit 10 -> 1, bit 11 -> 2)
//  on_out    out  1   ~segs_in[7] of the reported frame
//  err_out   out  1   reported frame has no matching segment pattern (code_out=0)
//  ovf_out   out  1   sticky: bus changed while a record was pending
//  ovf_clr   in   1   synchronous clear of ovf_out
// BEHAVIOUR
//  Reset: valid=0, code_out=0, digit_out=0, on_out=0, err_out=0, ovf_out=0; in_q=12'hFFF; FSM=S_TRACK.
//  Sampling: in_q <= segs_in every cycle. Counter clears when segs_in!=in_q; otherwise it increments, saturating.
//  Latency: if in_q first takes value V at edge k and segs_in holds V, valid rises at edge k+STABLE_CYCLES.
//  Pattern table [6:0] for codes 0..7: 7F,08,46,47,12,03,42,06. No match -> err_out=1, code_out=0.
//  Digit: exactly one of [11:9] low -> reportable frame.
//   All high (blank) -> never reported.
//   Two or more low -> reported with err_out=1, digit_out = lowest low index.
//  FSM:
//   S_TRACK: on stable reportable frame, load outputs, valid<=1, last<=in_q, go S_EMIT.
//            Stable blank -> go S_DONE with last<=in_q.
//   S_EMIT:  hold outputs and valid until ready. If segs_in!=in_q during S_EMIT, set ovf_out.
//            On ready: valid<=0 at that edge. If in_q!=last, go S_TRACK with counter cleared; else S_DONE.
//   S_DONE:  wait for in_q!=last, then go S_TRACK. The same frame is never reported twice.
//  Outputs are registered and change only on load; they are stable while valid=1.
//  ovf_out: ovf_clr and a set condition in the same cycle -> set wins.
//  Reset mid-record: valid drops immediately (async); no partial record survives.
//  Point bit [8] is ignored for decode.
// STRUCTURE
//  display_pkg: SEG_PAT[0:7] table, bit-position constants (SEG_H=7, SEG_PT=8, DIG_LSB=9), state encoding.
//  One sub-module: seg_pattern_dec (combinational 7-bit -> {hit, code[2:0]}), reused by the driver bench.
// TESTING
//  1. segs_in=12'hD03 held from reset release, ready=1
//     -> valid one cycle at k+4, code=5, digit=0, on=1, err=0.
//  2. segs_in=12'h77F held, ready=0 for 10 cycles then 1
//     -> valid held 10 cycles, code=0, digit=2; exactly one handshake, no repeat.
//  3. Bus toggles 12'hD03/12'hD08 every 2 cycles (STABLE_CYCLES=4)
//     -> valid never asserts; then hold 12'hD08 -> record with code=1.
//  4. segs_in=12'h97F (bits 10,9 low)
//     -> err=1, digit=0. segs_in=12'hD55 -> err=1, code=0. 12'hFFF -> no record.
//  5. Record pending (ready=0); bus changes to 12'hD06 and stays
//     -> ovf_out=1; after ready, second record code=7; ovf_clr -> ovf_out=0.
//  6. Assert rst while valid=1
//     -> valid=0 asynchronously, all outputs zero; after release, held frame re-reported once.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and types for the display bus readback
package display_pkg;

  // Bit positions on the 12-bit display bus
  localparam int SEG_H   = 7;
  localparam int SEG_PT  = 8;
  localparam int DIG_LSB = 9;

  // Raw segment patterns [6:0] that encode codes 0..7
  localparam logic [6:0] SEG_PAT [0:7] = '{
    7'h7F, 7'h08, 7'h46, 7'h47, 7'h12, 7'h03, 7'h42, 7'h06
  };

  typedef enum logic [1:0] {
    S_TRACK = 2'd0,
    S_EMIT  = 2'd1,
    S_DONE  = 2'd2
  } stateT;

endpackage

// File: rtl/seg_pattern_dec.sv
// rtl/seg_pattern_dec.sv - maps a 7-bit segment pattern back to its code
module seg_pattern_dec
  import display_pkg::*;
(
  input  logic [6:0] segs,
  output logic       hit,
  output logic [2:0] code
);

  // Table lookup; patterns are unique so at most one entry matches
  always_comb begin
    hit  = 1'b0;
    code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (segs == SEG_PAT[i]) begin
        hit  = 1'b1;
        code = 3'(i);
      end
    end
  end

endmodule

// File: rtl/display_readback.sv
// rtl/display_readback.sv - reports each stable display frame as a decoded record
module display_readback
  import display_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] segs_in,
  input  logic        ready,
  output logic        valid,
  output logic [2:0]  code_out,
  output logic [1:0]  digit_out,
  output logic        on_out,
  output logic        err_out,
  output logic        ovf_out,
  input  logic        ovf_clr
);

  // Counter saturates one below STABLE_CYCLES: the sample that loads in_q is the first one
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [11:0]      inQ;
  logic [11:0]      lastFrame;
  logic [CNT_W-1:0] stableCnt;
  stateT            state;
  stateT            nextState;
  logic             patHit;
  logic [2:0]       patCode;
  logic [2:0]       digEn;
  logic             blank;
  logic             multiDigit;
  logic [1:0]       digitSel;
  logic             busMoved;
  logic             stable;
  logic             loadRec;
  logic             saveLast;
  logic             clrCnt;
  logic             dropValid;

  seg_pattern_dec uDec (
    .segs (inQ[6:0]),
    .hit  (patHit),
    .code (patCode)
  );

  // Digit enables are active low on the bus; flip them once here
  assign digEn      = ~inQ[DIG_LSB +: 3];
  assign blank      = (digEn == 3'b000);
  assign multiDigit = ((digEn & (digEn - 3'd1)) != 3'b000);
  assign busMoved   = (segs_in != inQ);
  assign stable     = !busMoved && (stableCnt == CNT_MAX);

  // Lowest enabled digit wins when several are enabled
  always_comb begin
    digitSel = 2'd2;
    if (digEn[0])      digitSel = 2'd0;
    else if (digEn[1]) digitSel = 2'd1;
  end

  // Bus sampling register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inQ <= 12'hFFF;
    else     inQ <= segs_in;
  end

  // Stability counter: restarts on any bus change or when the FSM rearms tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      stableCnt <= '0;
    else if (busMoved || clrCnt)  stableCnt <= '0;
    else if (stableCnt != CNT_MAX) stableCnt <= stableCnt + CNT_W'(1);
  end

  // Remember the last frame handled so a held frame is not reported again
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           lastFrame <= 12'hFFF;
    else if (saveLast) lastFrame <= inQ;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_TRACK;
    else     state <= nextState;
  end

  // FSM next state and control strobes
  always_comb begin
    nextState = state;
    loadRec   = 1'b0;
    saveLast  = 1'b0;
    clrCnt    = 1'b0;
    dropValid = 1'b0;
    case (state)
      S_TRACK: begin
        if (stable) begin
          saveLast  = 1'b1;
          loadRec   = !blank;
          nextState = blank ? S_DONE : S_EMIT;
        end
      end
      S_EMIT: begin
        if (ready) begin
          dropValid = 1'b1;
          if (inQ != lastFrame) begin
            clrCnt    = 1'b1;
            nextState = S_TRACK;
          end else begin
            nextState = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (inQ != lastFrame) nextState = S_TRACK;
      end
      default: nextState = S_TRACK;
    endcase
  end

  // Record registers: loaded once per frame, frozen while valid is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      code_out  <= 3'd0;
      digit_out <= 2'd0;
      on_out    <= 1'b0;
      err_out   <= 1'b0;
    end else if (loadRec) begin
      valid     <= 1'b1;
      code_out  <= patHit ? patCode : 3'd0;
      digit_out <= digitSel;
      on_out    <= ~inQ[SEG_H];
      err_out   <= !patHit || multiDigit;
    end else if (dropValid) begin
      valid     <= 1'b0;
    end
  end

  // Sticky overflow: bus moved while a record was waiting; setting beats clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              ovf_out <= 1'b0;
    else if (state == S_EMIT && busMoved) ovf_out <= 1'b1;
    else if (ovf_clr)                     ovf_out <= 1'b0;
  end

endmodule

// File: tb/tb_display_readback.sv
// tb/tb_display_readback.sv - scoreboard bench for display_readback
module tb_display_readback;

  typedef struct packed {
    logic [2:0] code;
    logic [1:0] digit;
    logic       on;
    logic       err;
  } recT;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        ovfClr;
  logic [11:0] segs;
  logic        valid;
  logic [2:0]  code;
  logic [1:0]  digit;
  logic        on;
  logic        err;
  logic        ovf;

  logic [6:0]  patTab [8] = '{7'h7F, 7'h08, 7'h46, 7'h47, 7'h12, 7'h03, 7'h42, 7'h06};

  recT         sbQ [$];
  int          nCmp = 0;
  int          nFail = 0;
  int          validSeen = 0;
  logic [11:0] curVal;
  int          runLen;
  logic        ovfExp;

  display_readback #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .segs_in   (segs),
    .ready     (ready),
    .valid     (valid),
    .code_out  (code),
    .digit_out (digit),
    .on_out    (on),
    .err_out   (err),
    .ovf_out   (ovf),
    .ovf_clr   (ovfClr)
  );

  always #5 clk = ~clk;

  // Expected record for a frame, straight from the bus definition
  function automatic recT refDecode(input logic [11:0] v);
    recT r;
    int  lows;
    int  first;
    bit  hit;
    r = '0;
    lows = 0;
    first = 0;
    for (int i = 2; i >= 0; i--) begin
      if (!v[9+i]) begin
        lows++;
        first = i;
      end
    end
    hit = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (v[6:0] == patTab[c]) begin
        hit = 1'b1;
        r.code = 3'(c);
      end
    end
    r.digit = 2'(first);
    r.on    = ~v[7];
    r.err   = !hit || (lows > 1);
    return r;
  endfunction

  // A frame held for STABLE+1 samples is reported once, unless blank
  task automatic modelSample(input logic [11:0] v);
    if (v == curVal) begin
      runLen++;
    end else begin
      if (curVal[11:9] != 3'b111 && runLen == STABLE + 1) ovfExp = 1'b1;
      curVal = v;
      runLen = 1;
    end
    if (runLen == STABLE + 1 && v[11:9] != 3'b111) sbQ.push_back(refDecode(v));
  endtask

  task automatic driveCycle(input logic [11:0] v);
    segs = v;
    @(posedge clk);
    modelSample(v);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      driveCycle(segs);
      n++;
    end
    nCmp++;
    if (sbQ.size() != 0) begin
      nFail++;
      $display("FAIL %s_drain got=%0d pending required=0", name, sbQ.size());
    end
  endtask

  function automatic logic [11:0] randFrame();
    logic [2:0] en;
    logic [6:0] p;
    en = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) p = patTab[$urandom_range(0, 7)];
    else                           p = 7'($urandom);
    return {en, 1'($urandom), 1'($urandom), p};
  endfunction

  // Monitor: every accepted record is compared against the oldest expectation
  recT gotRec;
  recT expRec;
  always @(negedge clk) begin
    if (!rst && valid) begin
      validSeen++;
      if (ready) begin
        gotRec = {code, digit, on, err};
        nCmp++;
        if (sbQ.size() == 0) begin
          nFail++;
          $display("FAIL unexpected_record got=%0h required=none", gotRec);
        end else begin
          expRec = sbQ.pop_front();
          if (gotRec !== expRec) begin
            nFail++;
            $display("FAIL record got code=%0d digit=%0d on=%0d err=%0d required code=%0d digit=%0d on=%0d err=%0d",
                     gotRec.code, gotRec.digit, gotRec.on, gotRec.err,
                     expRec.code, expRec.digit, expRec.on, expRec.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [11:0] rv;
  int          rlen;
  int          held;

  initial begin
    rst = 1'b1; ready = 1'b1; ovfClr = 1'b0; segs = 12'hD03;
    curVal = 12'hFFF; runLen = 0; ovfExp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", valid, 0);
    check("reset_outputs", {code, digit, on, err, ovf}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: valid rises exactly STABLE edges after in_q first holds the frame
    repeat (4) driveCycle(12'hD03);
    check("t1_not_yet", valid, 0);
    driveCycle(12'hD03);
    check("t1_latency", valid, 1);
    driveCycle(12'hD03);
    check("t1_one_cycle", valid, 0);
    waitDrain("t1");

    // 2: backpressure holds the record, single handshake
    ready = 1'b0;
    repeat (5) driveCycle(12'h77F);
    check("t2_valid_up", valid, 1);
    held = 0;
    repeat (10) begin
      driveCycle(12'h77F);
      if (valid) held++;
    end
    check("t2_valid_held", held, 10);
    check("t2_digit_held", digit, 2);
    ready = 1'b1;
    repeat (6) driveCycle(12'h77F);
    check("t2_no_repeat", valid, 0);
    waitDrain("t2");

    // 3: bus never settles long enough, then settles on code 1
    validSeen = 0;
    repeat (6) begin
      repeat (2) driveCycle(12'hD03);
      repeat (2) driveCycle(12'hD08);
    end
    check("t3_no_valid", validSeen, 0);
    repeat (8) driveCycle(12'hD08);
    waitDrain("t3");

    // 4: multi-digit, unknown pattern, blank
    repeat (8) driveCycle(12'h97F);
    repeat (8) driveCycle(12'hD55);
    waitDrain("t4");
    validSeen = 0;
    repeat (10) driveCycle(12'hFFF);
    check("t4_blank_silent", validSeen, 0);

    // 5: bus moves while a record is pending
    check("t5_ovf_idle", ovf, 0);
    ready = 1'b0;
    repeat (5) driveCycle(12'hD03);
    check("t5_valid_up", valid, 1);
    repeat (3) driveCycle(12'hD06);
    check("t5_ovf_set", ovf, 1);
    check("t5_code_held", {valid, code}, {1'b1, 3'd5});
    ready = 1'b1;
    repeat (10) driveCycle(12'hD06);
    waitDrain("t5");
    check("t5_ovf_sticky", ovf, 1);
    ovfClr = 1'b1;
    driveCycle(12'hD06);
    ovfClr = 1'b0;
    check("t5_ovf_clr", ovf, 0);

    // Random frames of random hold lengths against the reference model
    ovfExp = 1'b0;
    for (int r = 0; r < 80; r++) begin
      do rv = randFrame(); while (rv == curVal);
      rlen = $urandom_range(1, 8);
      repeat (rlen) driveCycle(rv);
    end
    repeat (8) driveCycle(12'hFFF);
    waitDrain("rand");
    check("rand_ovf", ovf, ovfExp);

    // 6: reset while a record is pending
    ready = 1'b0;
    repeat (6) driveCycle(12'hD03);
    check("t6_valid_up", valid, 1);
    #3 rst = 1'b1;
    #1;
    check("t6_async_valid", valid, 0);
    check("t6_async_outputs", {code, digit, on, err, ovf}, 0);
    sbQ.delete();
    curVal = 12'hFFF;
    runLen = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    ready = 1'b1;
    repeat (8) driveCycle(12'hD03);
    waitDrain("t6");
    check("t6_done", valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
